// File: rtl/inv_monitor.sv
// Inverter health monitor: tracks a_in/y_in complementarity, declares sticky faults after MAX_LAG mismatches.
// Optional a_in period measurement is enabled with `define INV_MON_PERIOD_EN.
module inv_monitor #(
  parameter int MAX_LAG = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a_in,
  input  logic             y_in,
  output logic [1:0]       state,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LAG   = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [4:0] MAX_LAG_W = 5'(MAX_LAG);

  state_e           state_q;
  logic             a_q, y_q, a_prev_q;
  logic [3:0]       lag_q;
  logic             err_q;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [4:0]       lag_d;
  logic             mismatch, toggle;

  assign mismatch = (y_q == a_q);
  assign toggle   = a_q ^ a_prev_q;
  assign lag_d    = {1'b0, lag_q} + 5'd1;

  always_comb begin
    tog_d = tog_q;
    if (toggle && state_q != IDLE && tog_q != '1) tog_d = tog_q + 1'b1;
    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 1'b0;
      y_q       <= 1'b1;
      a_prev_q  <= 1'b0;
      lag_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      tog_q     <= '0;
    end else begin
      a_q      <= a_in;
      y_q      <= y_in;
      a_prev_q <= a_q;
      if (clr) begin
        // clear wins over any fault declaration or toggle increment this cycle
        tog_q     <= '0;
        err_cnt_q <= '0;
        err_q     <= 1'b0;
        lag_q     <= '0;
        state_q   <= en ? TRACK : IDLE;
      end else begin
        tog_q <= tog_d;
        case (state_q)
          IDLE: if (en) state_q <= TRACK;
          TRACK: begin
            if (!en) begin
              state_q <= IDLE;
              lag_q   <= '0;
            end else if (mismatch) begin
              lag_q <= 4'd1;
              if (MAX_LAG <= 1) begin
                state_q   <= FAULT;
                err_q     <= 1'b1;
                err_cnt_q <= err_cnt_d;
              end else begin
                state_q <= LAG;
              end
            end
          end
          LAG: begin
            if (!en || !mismatch) begin
              state_q <= en ? TRACK : IDLE;
              lag_q   <= '0;
            end else begin
              lag_q <= lag_d[3:0];
              if (lag_d >= MAX_LAG_W) begin
                state_q   <= FAULT;
                err_q     <= 1'b1;
                err_cnt_q <= err_cnt_d;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state      = state_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign toggle_cnt = tog_q;

`ifdef INV_MON_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, period_q;
  logic             seen_q, pv_q;
  logic             rise;

  assign rise = a_q & ~a_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      seen_q    <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (state_q != IDLE) begin
        if (rise) begin
          // the first edge only arms the measurement
          per_cnt_q <= CNT_W'(1);
          seen_q    <= 1'b1;
          if (seen_q) begin
            period_q <= per_cnt_q;
            pv_q     <= 1'b1;
          end
        end else if (per_cnt_q != '1) begin
          per_cnt_q <= per_cnt_q + 1'b1;
        end
      end
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_inv_monitor.sv
// Directed bench for inv_monitor: reset, toggle counting, lag/fault/clear table, period, mid-LAG reset.
module tb_inv_monitor;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, en, clr, a_in, y_in;
  logic [1:0]       state;
  logic             err;
  logic [7:0]       err_cnt;
  logic [CNT_W-1:0] toggle_cnt, period;
  logic             period_valid;

  int total = 0;
  int bad   = 0;

  inv_monitor #(.MAX_LAG(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a_in(a_in), .y_in(y_in),
    .state(state), .err(err), .err_cnt(err_cnt), .toggle_cnt(toggle_cnt),
    .period(period), .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
    chk({tag, "_tog"}, 32'(toggle_cnt), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_pv"}, 32'(period_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         en, clr, a, y;
    logic [1:0] st;
    bit         err;
    logic [7:0] ec;
  } vec_t;

  vec_t vec [24];
  int   pv_n;

  initial begin
    // inputs applied, then one clock, then state/err/err_cnt checked
    vec[0]  = '{1, 0, 0, 1, 2'd1, 0, 8'd0};  // IDLE -> TRACK
    vec[1]  = '{1, 0, 0, 1, 2'd1, 0, 8'd0};
    vec[2]  = '{1, 0, 0, 0, 2'd1, 0, 8'd0};  // mismatch being registered
    vec[3]  = '{1, 0, 0, 1, 2'd2, 0, 8'd0};  // single-cycle LAG
    vec[4]  = '{1, 0, 0, 1, 2'd1, 0, 8'd0};
    vec[5]  = '{1, 0, 0, 0, 2'd1, 0, 8'd0};  // stuck mismatch
    vec[6]  = '{1, 0, 0, 0, 2'd2, 0, 8'd0};
    vec[7]  = '{1, 0, 0, 0, 2'd3, 1, 8'd1};  // fault two cycles after first mismatch
    vec[8]  = '{1, 0, 0, 0, 2'd3, 1, 8'd1};
    vec[9]  = '{1, 0, 0, 0, 2'd3, 1, 8'd1};
    vec[10] = '{1, 0, 0, 1, 2'd3, 1, 8'd1};  // restored, still held
    vec[11] = '{0, 0, 0, 1, 2'd3, 1, 8'd1};  // en low does not leave FAULT
    vec[12] = '{1, 1, 0, 1, 2'd1, 0, 8'd0};  // clr with en -> TRACK
    vec[13] = '{1, 0, 0, 1, 2'd1, 0, 8'd0};
    vec[14] = '{1, 0, 0, 0, 2'd1, 0, 8'd0};
    vec[15] = '{1, 0, 0, 0, 2'd2, 0, 8'd0};
    vec[16] = '{0, 0, 0, 0, 2'd0, 0, 8'd0};  // en low + mismatch in LAG -> IDLE
    vec[17] = '{0, 0, 0, 1, 2'd0, 0, 8'd0};
    vec[18] = '{1, 0, 0, 1, 2'd1, 0, 8'd0};
    vec[19] = '{1, 0, 0, 0, 2'd1, 0, 8'd0};
    vec[20] = '{1, 0, 0, 0, 2'd2, 0, 8'd0};
    vec[21] = '{1, 1, 0, 0, 2'd1, 0, 8'd0};  // clr on threshold cycle: no fault
    vec[22] = '{1, 0, 0, 1, 2'd2, 0, 8'd0};  // registered mismatch from row 21
    vec[23] = '{1, 0, 0, 1, 2'd1, 0, 8'd0};

    en = 1'b0; clr = 1'b0; a_in = 1'b0; y_in = 1'b1; rst = 1'b1;
    step();
    do_reset();
    chk_reset("rst");

    for (int i = 0; i < 24; i++) begin
      en = vec[i].en; clr = vec[i].clr; a_in = vec[i].a; y_in = vec[i].y;
      step();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vec[i].st));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vec[i].err));
      chk($sformatf("v%0d_errcnt", i), 32'(err_cnt), 32'(vec[i].ec));
    end
    clr = 1'b0;

    // 10 toggles, 10 cycles apart, inverter healthy
    en = 1'b1; a_in = 1'b0; y_in = 1'b1;
    do_reset();
    pv_n = 0;
    for (int t = 0; t < 10; t++) begin
      for (int c = 0; c < 10; c++) begin
        step();
        if (period_valid) pv_n++;
      end
      a_in = ~a_in; y_in = ~a_in;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (period_valid) pv_n++;
    end
    chk("tog_state", 32'(state), 1);
    chk("tog_err", 32'(err), 0);
    chk("tog_cnt", 32'(toggle_cnt), 10);
`ifdef INV_MON_PERIOD_EN
    chk("period_val", 32'(period), 20);
    chk("period_pulses", 32'(pv_n), 4);
`else
    chk("period_val", 32'(period), 0);
    chk("period_pulses", 32'(pv_n), 0);
`endif

    // reset while in LAG with 7 toggles counted
    en = 1'b1; a_in = 1'b0; y_in = 1'b1;
    do_reset();
    step();
    for (int t = 0; t < 7; t++) begin
      a_in = ~a_in; y_in = ~a_in;
      step(); step(); step();
    end
    y_in = a_in;
    step();
    step();
    chk("lag_state", 32'(state), 2);
    chk("lag_tog", 32'(toggle_cnt), 7);
    rst = 1'b1; clr = 1'b1;
    step();
    chk_reset("midlag");
    rst = 1'b0; clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
